// File: rtl/axi_stream_strip_header.sv
// AXI-Stream header strip: drops S leading bytes of each packet (S latched on the
// first accepted beat) and realigns the remaining payload to beat boundaries.
// Outputs are registered; ready_in is the only combinational output.
module axi_stream_strip_header #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic [BYTE_CNT_WD-1:0]  strip_cnt,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);

    localparam int unsigned CNT_WD = BYTE_CNT_WD + 1;
    localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DATA_BYTE_WD);

    typedef enum logic [1:0] {ST_FIRST, ST_BODY, ST_FLUSH} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WD-1:0]      resid;
    logic [BYTE_CNT_WD-1:0]  strip_q;
    logic [CNT_WD-1:0]       flush_cnt;

    logic                    out_free;
    logic                    accept;
    logic [BYTE_CNT_WD-1:0]  s_cur;
    logic [CNT_WD-1:0]       s_cur_ext;
    logic [CNT_WD-1:0]       s_q_ext;
    logic [CNT_WD-1:0]       w_minus_s;
    logic [CNT_WD-1:0]       n_in;
    logic [DATA_WD-1:0]      in_shifted;
    logic [DATA_WD-1:0]      in_tail;

    logic                    emit;
    logic [DATA_WD-1:0]      emit_data;
    logic [DATA_WD-1:0]      emit_data_m;
    logic [DATA_BYTE_WD-1:0] emit_keep;
    logic                    emit_last;
    logic                    load_resid;
    logic                    load_strip;
    logic                    load_flush;
    logic [CNT_WD-1:0]       flush_cnt_nxt;

    // k leading ones from the MSB (k = 0..DATA_BYTE_WD)
    function automatic logic [DATA_BYTE_WD-1:0] ones_msb(input logic [CNT_WD-1:0] k);
        logic [DATA_BYTE_WD-1:0] all_ones;
        all_ones = '1;
        return ~(all_ones >> k);
    endfunction

    // Expand byte enables to a bit mask
    function automatic logic [DATA_WD-1:0] keep_mask(input logic [DATA_BYTE_WD-1:0] keep);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
            m[8*i +: 8] = {8{keep[i]}};
        end
        return m;
    endfunction

    assign out_free  = !valid_out || ready_out;
    assign ready_in  = rst_n && out_free && (state != ST_FLUSH);
    assign accept    = valid_in && ready_in;
    assign s_cur     = (state == ST_FIRST) ? strip_cnt : strip_q;
    assign s_cur_ext = {1'b0, s_cur};
    assign s_q_ext   = {1'b0, strip_q};
    assign w_minus_s = FULL_CNT - s_q_ext;

    // Byte count of the incoming beat and the two realignment shifts
    always_comb begin
        n_in = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
            n_in = n_in + CNT_WD'(keep_in[i]);
        end
        in_shifted = data_in << {s_cur, 3'b000};
        in_tail    = data_in >> {w_minus_s, 3'b000};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; FLUSH only when the last beat leaves bytes beyond the joined beat
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FIRST: begin
                if (accept && !last_in) state_nxt = ST_BODY;
            end
            ST_BODY: begin
                if (accept && last_in) begin
                    state_nxt = ((s_q_ext != '0) && (n_in > s_q_ext)) ? ST_FLUSH : ST_FIRST;
                end
            end
            ST_FLUSH: begin
                if (out_free) state_nxt = ST_FIRST;
            end
            default: state_nxt = ST_FIRST;
        endcase
    end

    // Output beat composition and residual/count load enables
    always_comb begin
        emit          = 1'b0;
        emit_data     = '0;
        emit_keep     = '0;
        emit_last     = 1'b0;
        load_resid    = 1'b0;
        load_strip    = 1'b0;
        load_flush    = 1'b0;
        flush_cnt_nxt = n_in - s_q_ext;
        case (state)
            ST_FIRST: begin
                if (accept) begin
                    load_resid = 1'b1;
                    load_strip = 1'b1;
                    if (strip_cnt == '0) begin
                        emit      = 1'b1;
                        emit_data = data_in;
                        emit_keep = keep_in;
                        emit_last = last_in;
                    end else if (last_in) begin
                        emit      = 1'b1;
                        emit_data = in_shifted;
                        emit_keep = (n_in > s_cur_ext) ? ones_msb(n_in - s_cur_ext) : '0;
                        emit_last = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    load_resid = 1'b1;
                    emit       = 1'b1;
                    if (strip_q == '0) begin
                        emit_data = data_in;
                        emit_keep = keep_in;
                        emit_last = last_in;
                    end else begin
                        emit_data = resid | in_tail;
                        emit_keep = '1;
                        if (last_in) begin
                            if (n_in <= s_q_ext) begin
                                emit_keep = ones_msb(w_minus_s + n_in);
                                emit_last = 1'b1;
                            end else begin
                                load_flush = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    emit      = 1'b1;
                    emit_data = resid;
                    emit_keep = ones_msb(flush_cnt);
                    emit_last = 1'b1;
                end
            end
            default: ;
        endcase
        emit_data_m = emit_data & keep_mask(emit_keep);
    end

    // Output, residual and strip-count registers; outputs hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
            resid     <= '0;
            strip_q   <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_free) begin
                valid_out <= emit;
                data_out  <= emit_data_m;
                keep_out  <= emit_keep;
                last_out  <= emit_last;
            end
            if (load_resid) resid     <= in_shifted;
            if (load_strip) strip_q   <= strip_cnt;
            if (load_flush) flush_cnt <= flush_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header (W=4 bytes): directed vector table,
// reset-in-packet sequence and a randomized run against a byte-strip scoreboard.
module tb_axi_stream_strip_header;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic [1:0]  strip_cnt;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;

    int checks = 0;
    int errors = 0;

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .keep_in   (keep_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .strip_cnt (strip_cnt),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out),
        .ready_out (ready_out)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic [3:0]  kin;
        logic        lin;
        logic [1:0]  sin;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic        erdy;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        fa;
    } exp_t;

    vec_t tbl [19];
    exp_t sbq [$];

    logic        mon_en = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] sv_d;
    logic [3:0]  sv_k;
    logic        sv_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            ready_out = 1'b1;
            valid_in  = tbl[i].vin;
            data_in   = tbl[i].din;
            keep_in   = tbl[i].kin;
            last_in   = tbl[i].lin;
            strip_cnt = tbl[i].sin;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid", i), 32'(valid_out), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("row%0d data", i), data_out, tbl[i].ed);
                chk($sformatf("row%0d keep", i), 32'(keep_out), 32'(tbl[i].ek));
                chk($sformatf("row%0d last", i), 32'(last_out), 32'(tbl[i].el));
            end
            chk($sformatf("row%0d ready_in", i), 32'(ready_in), 32'(tbl[i].erdy));
        end
    endtask

    task automatic run_random();
        logic [7:0]  bq [$];
        logic [31:0] bd [4];
        logic [3:0]  bk [4];
        logic [3:0]  kf;
        exp_t        e;
        int          s, b, n, nb, idx, guard;
        bit          acc;
        logic [31:0] d;
        mon_en = 1'b1;
        for (int p = 0; p < 200; p++) begin
            s = int'($urandom_range(0, 3));
            b = int'($urandom_range(1, 4));
            n = int'($urandom_range(1, 4));
            bq.delete();
            for (int i = 0; i < b; i++) begin
                d     = $urandom;
                nb    = (i == b - 1) ? n : 4;
                kf    = 4'hF;
                bd[i] = d;
                bk[i] = ~(kf >> nb);
                for (int j = 0; j < nb; j++) bq.push_back(d[31-8*j -: 8]);
            end
            for (int j = 0; j < s; j++) void'(bq.pop_front());
            if (bq.size() == 0) begin
                e.d = '0; e.k = '0; e.l = 1'b1; e.fa = 1'b0;
                sbq.push_back(e);
            end else begin
                idx = 0;
                while (bq.size() > 0) begin
                    e.d = '0;
                    e.k = '0;
                    for (int j = 0; j < 4 && bq.size() > 0; j++) begin
                        e.d[31-8*j -: 8] = bq.pop_front();
                        e.k[3-j] = 1'b1;
                    end
                    e.l  = (bq.size() == 0);
                    e.fa = (b >= 2 && s > 0 && n > s && idx == b - 2);
                    sbq.push_back(e);
                    idx++;
                end
            end
            for (int i = 0; i < b; i++) begin
                acc   = 1'b0;
                guard = 0;
                while (!acc) begin
                    @(negedge clk);
                    ready_out = 1'($urandom_range(0, 1));
                    valid_in  = ($urandom_range(0, 3) != 0);
                    data_in   = bd[i];
                    keep_in   = bk[i];
                    last_in   = (i == b - 1);
                    strip_cnt = (i == 0) ? 2'(s) : 2'($urandom_range(0, 3));
                    #1;
                    acc = valid_in && ready_in;
                    guard++;
                    if (guard > 500) begin
                        $display("FAIL input stall timeout: packet %0d beat %0d never accepted", p, i);
                        $fatal(1, "stalled");
                    end
                end
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        guard = 0;
        while (sbq.size() > 0 && guard < 2000) begin
            @(negedge clk);
            ready_out = 1'($urandom_range(0, 1));
            guard++;
        end
        @(negedge clk);
        ready_out = 1'b1;
        #3;
        mon_en = 1'b0;
        chk("drain leftover beats", 32'(sbq.size()), 32'd0);
    endtask

    // Random-phase monitor: scoreboard compare, stall stability, FLUSH backpressure
    initial forever begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            if (hold_prev) begin
                chk("stall valid", 32'(valid_out), 32'd1);
                chk("stall data", data_out, sv_d);
                chk("stall keep", 32'(keep_out), 32'(sv_k));
                chk("stall last", 32'(last_out), 32'(sv_l));
            end
            if (valid_out) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious beat: got data %h keep %h, expected no beat", data_out, keep_out);
                end else begin
                    chk("rand data", data_out, sbq[0].d);
                    chk("rand keep", 32'(keep_out), 32'(sbq[0].k));
                    chk("rand last", 32'(last_out), 32'(sbq[0].l));
                    if (sbq[0].fa) chk("flush ready_in", 32'(ready_in), 32'd0);
                    if (ready_out) void'(sbq.pop_front());
                end
            end
            hold_prev = valid_out && !ready_out;
            sv_d = data_out;
            sv_k = keep_out;
            sv_l = last_out;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        // S=1 three-beat packet through FLUSH
        tbl[0]  = '{1'b1, 32'h00112233, 4'hF, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 32'h44556677, 4'hF, 1'b0, 2'd3, 1'b1, 32'h11223344, 4'hF, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 32'h8899AABB, 4'hC, 1'b1, 2'd3, 1'b1, 32'h55667788, 4'hF, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,        4'h0, 1'b0, 2'd3, 1'b1, 32'h99000000, 4'h8, 1'b1, 1'b1};
        // S=2 same packet, no flush beat
        tbl[4]  = '{1'b1, 32'h00112233, 4'hF, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 32'h44556677, 4'hF, 1'b0, 2'd0, 1'b1, 32'h22334455, 4'hF, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 32'h8899AABB, 4'hC, 1'b1, 2'd1, 1'b1, 32'h66778899, 4'hF, 1'b1, 1'b1};
        // S=0 pass-through
        tbl[7]  = '{1'b1, 32'h01020304, 4'hF, 1'b0, 2'd0, 1'b1, 32'h01020304, 4'hF, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 32'h05060708, 4'hF, 1'b0, 2'd3, 1'b1, 32'h05060708, 4'hF, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 32'h090A0B00, 4'hE, 1'b1, 2'd2, 1'b1, 32'h090A0B00, 4'hE, 1'b1, 1'b1};
        // single-beat packets
        tbl[10] = '{1'b1, 32'hDEADBEEF, 4'hE, 1'b1, 2'd3, 1'b1, 32'h00000000, 4'h0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 2'd1, 1'b1, 32'hADBEEF00, 4'hE, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 32'h0,        4'h0, 1'b0, 2'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1};
        // packet cut by reset
        tbl[13] = '{1'b1, 32'h00112233, 4'hF, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 32'h44556677, 4'hF, 1'b0, 2'd2, 1'b1, 32'h11223344, 4'hF, 1'b0, 1'b1};
        // packet after reset, S=2
        tbl[15] = '{1'b1, 32'h00112233, 4'hF, 1'b0, 2'd2, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 32'h44556677, 4'hF, 1'b0, 2'd1, 1'b1, 32'h22334455, 4'hF, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 32'h8899AABB, 4'hC, 1'b1, 2'd0, 1'b1, 32'h66778899, 4'hF, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 32'h0,        4'h0, 1'b0, 2'd0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1};

        rst_n     = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        keep_in   = '0;
        last_in   = 1'b0;
        strip_cnt = '0;
        ready_out = 1'b1;
        #3;
        chk("reset valid_out", 32'(valid_out), 32'd0);
        chk("reset data_out", data_out, 32'd0);
        chk("reset keep_out", 32'(keep_out), 32'd0);
        chk("reset last_out", 32'(last_out), 32'd0);
        chk("reset ready_in", 32'(ready_in), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset ready_in", 32'(ready_in), 32'd1);

        run_rows(0, 12);

        run_rows(13, 14);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midpkt reset valid_out", 32'(valid_out), 32'd0);
        chk("midpkt reset data_out", data_out, 32'd0);
        chk("midpkt reset keep_out", 32'(keep_out), 32'd0);
        chk("midpkt reset last_out", 32'(last_out), 32'd0);
        chk("midpkt reset ready_in", 32'(ready_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midpkt release ready_in", 32'(ready_in), 32'd1);
        run_rows(15, 18);

        run_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
